video_timing_gen: RTL and testbench

- Parametrised raster timing and test-pattern generator, successor to the fixed single-mode core generator.
- Produces the pixel clock enable, H/V counters, sync/blank/DE and a multi-channel test pattern.
- Supports run-time NTSC/PAL line-count selection, 2x scandouble mode and per-channel colour masking.
- Sits between the emu top and the VGA_* / CE_PIXEL outputs; driven from clk_sys.

---
 rtl/video_timing_pkg.sv | 29 ++
 rtl/video_pattern_gen.sv | 122 ++++++++++++
 rtl/video_timing_gen.sv | 145 ++++++++++++++
 tb/tb_video_timing_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator and its pattern source.
// Optional feature macro used by this design: VIDEO_TIMING_NOISE_EN.
package video_timing_pkg;

  localparam int HCNT_W = 12;
  localparam int VCNT_W = 11;
  localparam int LFSR_W = 16;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic pal;
    logic dbl;
  } mode_t;

  typedef enum logic [1:0] {
    COL_ALL = 2'd0,
    COL_R   = 2'd1,
    COL_G   = 2'd2,
    COL_B   = 2'd3
  } col_mask_e;

  function automatic logic [VCNT_W-1:0] vscale(input int lines, input logic dbl);
    return dbl ? VCNT_W'(2 * lines) : VCNT_W'(lines);
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Test-pattern source: 8 vertical colour bars, or an LFSR noise field when
// VIDEO_TIMING_NOISE_EN is defined; per-channel masking applied last.
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int CW       = 8,
  parameter int H_ACTIVE = 320
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic              de,
  input  logic              hblank,
  input  logic [VCNT_W-1:0] row,
  input  logic [1:0]        col,
  output logic [CW-1:0]     video_r,
  output logic [CW-1:0]     video_g,
  output logic [CW-1:0]     video_b
);

  col_mask_e     col_sel;
  logic          r_en, g_en, b_en;
  logic [CW-1:0] src_r, src_g, src_b;
  logic [CW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic          unused_ok;

  assign col_sel = col_mask_e'(col);
  assign r_en    = (col_sel == COL_ALL) || (col_sel == COL_R);
  assign g_en    = (col_sel == COL_ALL) || (col_sel == COL_G);
  assign b_en    = (col_sel == COL_ALL) || (col_sel == COL_B);

`ifdef VIDEO_TIMING_NOISE_EN
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (ce_pix && de) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign src_r     = lfsr_q[LFSR_W-1 -: CW];
  assign src_g     = lfsr_q[LFSR_W-1 -: CW];
  assign src_b     = lfsr_q[LFSR_W-1 -: CW];
  assign unused_ok = &{1'b0, row, hblank};
`else
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int PX_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(BAR_W - 1);
  // Reset leaves the raster on pixel 0, so the first counted pixel is pixel 1.
  localparam logic [PX_W-1:0] PX_RST  = PX_W'(1 % BAR_W);
  localparam logic [2:0]      BAR_RST = 3'(1 / BAR_W);

  logic [PX_W-1:0] px_q, px_d;
  logic [2:0]      bar_q, bar_d;

  always_comb begin
    px_d  = px_q;
    bar_d = bar_q;
    if (ce_pix) begin
      if (hblank) begin
        px_d  = '0;
        bar_d = '0;
      end else if (px_q == PX_LAST) begin
        px_d  = '0;
        bar_d = bar_q + 3'd1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q  <= PX_RST;
      bar_q <= BAR_RST;
    end else begin
      px_q  <= px_d;
      bar_q <= bar_d;
    end
  end

  assign src_r     = {CW{bar_q[2]}};
  assign src_g     = {CW{bar_q[1]}};
  assign src_b     = {CW{bar_q[0]}};
  // Bars are vertical, so the source row never changes the picture.
  assign unused_ok = &{1'b0, row};
`endif

  always_comb begin
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    if (ce_pix) begin
      r_d = (de && r_en) ? src_r : '0;
      g_d = (de && g_en) ? src_g : '0;
      b_d = (de && b_en) ? src_b : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign video_r = r_q;
  assign video_g = g_q;
  assign video_b = b_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel enable, H/V counters, sync/blank/DE and test pattern,
// with frame-latched NTSC/PAL and 1x/2x modes. Noise pattern via VIDEO_TIMING_NOISE_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CE_DIV       = 4,
  parameter int CW           = 8,
  parameter int H_ACTIVE     = 320,
  parameter int H_FP         = 8,
  parameter int H_SYNC       = 32,
  parameter int H_TOTAL      = 400,
  parameter int V_ACTIVE     = 240,
  parameter int V_FP         = 4,
  parameter int V_SYNC       = 3,
  parameter int V_TOTAL_NTSC = 262,
  parameter int V_TOTAL_PAL  = 312
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pal,
  input  logic              scandouble,
  input  logic [1:0]        col,
  output logic              ce_pix,
  output logic [HCNT_W-1:0] hcnt,
  output logic [VCNT_W-1:0] vcnt,
  output logic              hblank,
  output logic              vblank,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start,
  output logic [CW-1:0]     video_r,
  output logic [CW-1:0]     video_g,
  output logic [CW-1:0]     video_b
);

  localparam int DIV_W = $clog2(CE_DIV);
  localparam logic [DIV_W-1:0]  DIV_MAX_1X = DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_MAX_2X = DIV_W'(CE_DIV / 2 - 1);
  localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_ACT      = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0] HS_START   = HCNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCNT_W-1:0] HS_END     = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);

  logic [DIV_W-1:0]  div_q, div_d, div_max;
  logic              ce_q, ce_d;
  mode_t             mode_q, mode_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d, v_last, row;
  logic              hblank_q, hblank_d, vblank_q, vblank_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              frame_start_q, frame_start_d;
  logic              h_wrap, v_wrap, de_d;

  always_comb begin
    div_max = mode_q.dbl ? DIV_MAX_2X : DIV_MAX_1X;
    ce_d    = (div_q >= div_max);
    div_d   = ce_d ? '0 : div_q + 1'b1;
    v_last  = vscale(mode_q.pal ? V_TOTAL_PAL : V_TOTAL_NTSC, mode_q.dbl) - 1'b1;
    h_wrap  = (hcnt_q == H_LAST);
    v_wrap  = (vcnt_q == v_last);

    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    mode_d        = mode_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = frame_start_q;

    if (ce_q) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      if (h_wrap) vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
      // Mode (and with it the divider length) only changes at the frame boundary.
      if (h_wrap && v_wrap) begin
        mode_d.pal = pal;
        mode_d.dbl = scandouble;
      end
      frame_start_d = h_wrap && v_wrap;
      hblank_d      = (hcnt_d >= H_ACT);
      hsync_d       = (hcnt_d >= HS_START) && (hcnt_d < HS_END);
      vblank_d      = (vcnt_d >= vscale(V_ACTIVE, mode_d.dbl));
      vsync_d       = (vcnt_d >= vscale(V_ACTIVE + V_FP, mode_d.dbl)) &&
                      (vcnt_d <  vscale(V_ACTIVE + V_FP + V_SYNC, mode_d.dbl));
    end

    de_d = ~(hblank_d | vblank_d);
    row  = mode_d.dbl ? (vcnt_d >> 1) : vcnt_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      ce_q          <= 1'b0;
      mode_q        <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      ce_q          <= ce_d;
      mode_q        <= mode_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Fed with next-state timing so the pattern lands on the same edge as the counters.
  video_pattern_gen #(
    .CW       (CW),
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .clk     (clk),
    .reset_n (reset_n),
    .ce_pix  (ce_q),
    .de      (de_d),
    .hblank  (hblank_d),
    .row     (row),
    .col     (col),
    .video_r (video_r),
    .video_g (video_g),
    .video_b (video_b)
  );

  assign ce_pix      = ce_q;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = ~(hblank_q | vblank_q);
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a reduced raster so whole frames fit.
`timescale 1ns/1ps
module tb_video_timing_gen;
  import video_timing_pkg::*;

  localparam int CE_DIV       = 4;
  localparam int CW           = 8;
  localparam int H_ACTIVE     = 32;
  localparam int H_FP         = 2;
  localparam int H_SYNC       = 4;
  localparam int H_TOTAL      = 40;
  localparam int V_ACTIVE     = 12;
  localparam int V_FP         = 2;
  localparam int V_SYNC       = 2;
  localparam int V_TOTAL_NTSC = 20;
  localparam int V_TOTAL_PAL  = 24;
  localparam int W            = 3 * CW + 29;
  localparam int DE_BIT       = 3 * CW + 1;
  localparam int VB_BIT       = 3 * CW + 4;
  localparam int HB_BIT       = 3 * CW + 5;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              pal = 1'b0;
  logic              scandouble = 1'b0;
  logic [1:0]        col = 2'd0;
  logic              ce_pix;
  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic              hblank, vblank, hsync, vsync, de, frame_start;
  logic [CW-1:0]     video_r, video_g, video_b;

  always #5 clk = ~clk;

  video_timing_gen #(
    .CE_DIV(CE_DIV), .CW(CW), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC),
    .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC),
    .V_TOTAL_NTSC(V_TOTAL_NTSC), .V_TOTAL_PAL(V_TOTAL_PAL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pal(pal), .scandouble(scandouble), .col(col),
    .ce_pix(ce_pix), .hcnt(hcnt), .vcnt(vcnt), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
    .video_r(video_r), .video_g(video_g), .video_b(video_b)
  );

  // ---------------- scoreboard and reference model ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rst_vec;
  int          m_h, m_v;
  logic        m_pal, m_dbl, m_fs;
  logic [15:0] m_lfsr;

  function automatic logic [W-1:0] dut_vec();
    return {hcnt, vcnt, hblank, vblank, hsync, vsync, de, frame_start, video_r, video_g, video_b};
  endfunction

  function automatic logic [W-1:0] model_vec();
    int k, bar;
    logic hb, vb, hs, vs, d;
    logic [CW-1:0] sr, sg, sb, r, g, b;
    k  = m_dbl ? 2 : 1;
    hb = (m_h >= H_ACTIVE);
    hs = (m_h >= H_ACTIVE + H_FP) && (m_h < H_ACTIVE + H_FP + H_SYNC);
    vb = (m_v >= V_ACTIVE * k);
    vs = (m_v >= (V_ACTIVE + V_FP) * k) && (m_v < (V_ACTIVE + V_FP + V_SYNC) * k);
    d  = !(hb || vb);
`ifdef VIDEO_TIMING_NOISE_EN
    sr = m_lfsr[15 -: CW];
    sg = m_lfsr[15 -: CW];
    sb = m_lfsr[15 -: CW];
    bar = 0;
`else
    bar = m_h / (H_ACTIVE / 8);
    sr = ((bar & 4) != 0) ? '1 : '0;
    sg = ((bar & 2) != 0) ? '1 : '0;
    sb = ((bar & 1) != 0) ? '1 : '0;
`endif
    r = (d && (col == 2'd0 || col == 2'd1)) ? sr : '0;
    g = (d && (col == 2'd0 || col == 2'd2)) ? sg : '0;
    b = (d && (col == 2'd0 || col == 2'd3)) ? sb : '0;
    return {12'(m_h), 11'(m_v), hb, vb, hs, vs, d, m_fs, r, g, b};
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_pal = 1'b0; m_dbl = 1'b0; m_fs = 1'b0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_step();
    int vt;
    vt   = (m_pal ? V_TOTAL_PAL : V_TOTAL_NTSC) * (m_dbl ? 2 : 1);
    m_fs = 1'b0;
    if (m_h == H_TOTAL - 1) begin
      m_h = 0;
      if (m_v == vt - 1) begin
        m_v = 0; m_fs = 1'b1; m_pal = pal; m_dbl = scandouble;
      end else m_v++;
    end else m_h++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_and_check();
    logic [W-1:0] e;
    model_step();
    e = model_vec();
    exp_q.push_back(e);
`ifdef VIDEO_TIMING_NOISE_EN
    if (e[DE_BIT]) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (dut_vec() !== e)
      $display("FAIL pixel h=%0d v=%0d: got %h required %h", m_h, m_v, dut_vec(), e);
    else n_pass++;
  endtask

  task automatic wait_ce(output int n);
    n = 0;
    do begin tick(); n++; end while (ce_pix !== 1'b1 && n < 16);
  endtask

  task automatic step();
    int n, exp_gap;
    exp_gap = m_dbl ? CE_DIV / 2 : CE_DIV;
    wait_ce(n);
    n_checks++;
    if (n + 1 != exp_gap) $display("FAIL ce_period: got %0d required %0d", n + 1, exp_gap);
    else n_pass++;
    advance_and_check();
  endtask

  task automatic run_to_frame_start(input string name, input int exp_n);
    int n;
    n = 0;
    do begin step(); n++; end while (frame_start !== 1'b1 && n < 4000);
    n_checks++;
    if (n != exp_n) $display("FAIL %s: pixels to frame_start got %0d required %0d", name, n, exp_n);
    else n_pass++;
  endtask

  task automatic release_reset();
    int n;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (ce_pix !== 1'b1 && n < 16);
    n_checks++;
    if (n != CE_DIV) $display("FAIL first_ce: clk count got %0d required %0d", n, CE_DIV);
    else n_pass++;
    advance_and_check();
    n_checks++;
    if (ce_pix !== 1'b0) $display("FAIL ce_width: ce_pix got %b required 0", ce_pix);
    else n_pass++;
  endtask

  task automatic check_reset_state(input string name);
    n_checks++;
    if (dut_vec() !== rst_vec) $display("FAIL %s: got %h required %h", name, dut_vec(), rst_vec);
    else n_pass++;
    n_checks++;
    if (ce_pix !== 1'b0) $display("FAIL %s_ce: got %b required 0", name, ce_pix);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; pal = 1'b0; scandouble = 1'b0; col = 2'd0;
    model_reset();
    repeat (10) tick();
    check_reset_state("reset_values");
    release_reset();
  endtask

  task automatic test_ntsc();
    run_to_frame_start("ntsc_first_wrap", H_TOTAL * V_TOTAL_NTSC - 1);
    run_to_frame_start("ntsc_frame", H_TOTAL * V_TOTAL_NTSC);
  endtask

  task automatic test_pal_switch();
    int n;
    n = 0;
    while (!(m_v == 5 && m_h == 0) && n < 1000) begin step(); n++; end
    pal = 1'b1;
    run_to_frame_start("pal_current_frame", (V_TOTAL_NTSC - 5) * H_TOTAL);
    run_to_frame_start("pal_frame", H_TOTAL * V_TOTAL_PAL);
  endtask

  task automatic test_scandouble();
    pal = 1'b0;
    scandouble = 1'b1;
    run_to_frame_start("sd_pending_frame", H_TOTAL * V_TOTAL_PAL);
    run_to_frame_start("sd_frame", H_TOTAL * V_TOTAL_NTSC * 2);
  endtask

  task automatic test_col_mask();
    for (int c = 1; c <= 3; c++) begin
      col = 2'(c);
      repeat (H_TOTAL) step();
    end
    col = 2'd0;
  endtask

  task automatic test_mid_reset();
    int n;
    pal = 1'b1;
    scandouble = 1'b1;
    n = 0;
    while (!(m_v == 5 && m_h == 20) && n < 2000) begin step(); n++; end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    model_reset();
    repeat (3) tick();
    release_reset();
    run_to_frame_start("post_reset_ntsc_1x", H_TOTAL * V_TOTAL_NTSC - 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_vec = '0;
    rst_vec[HB_BIT] = 1'b1;
    rst_vec[VB_BIT] = 1'b1;
    test_reset();
    test_ntsc();
    test_pal_switch();
    test_scandouble();
    test_col_mask();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
